// File: rtl/operand_decode_stage_pkg.sv
// Shared types for the operand-decode stage: operand-field modes, control flags
// and helpers that locate operand fields inside the machine word.
package operand_pkg;

    typedef enum logic [1:0] {
        MODE_IMM = 2'd0,
        MODE_MEM = 2'd1,
        MODE_REG = 2'd2
    } mode_e;

    typedef struct packed {
        logic reg_dst;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
    } ctrl_t;

    localparam int CTRL_W   = 4;
    localparam int FIELD_F0 = 0;
    localparam int FIELD_F1 = 1;
    localparam int FIELD_F2 = 2;

    // Operand fields are packed back to back from bit 0, one register address each.
    function automatic int field_lsb(input int idx, input int reg_aw);
        return idx * reg_aw;
    endfunction

    function automatic mode_e decode_mode(input ctrl_t c);
        mode_e m;
        if (!c.reg_dst) begin
            m = MODE_IMM;
        end else if (c.mem_to_reg || c.mem_write || c.branch) begin
            m = MODE_MEM;
        end else begin
            m = MODE_REG;
        end
        return m;
    endfunction

endpackage

// File: rtl/operand_decode_stage_if.sv
// Bus between fetch/control decode, the register file, execute and the stage.
interface operand_decode_stage_if #(
    parameter int INSTR_W = 9,
    parameter int NREGS   = 4,
    parameter int DATA_W  = 8
);
    localparam int REG_AW = $clog2(NREGS);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] mach_code;
    logic               RegDst;
    logic               MemtoReg;
    logic               MemWrite;
    logic               Branch;
    logic [REG_AW-1:0]  rd_addr_a;
    logic [REG_AW-1:0]  rd_addr_b;
    logic [DATA_W-1:0]  rd_data_a;
    logic [DATA_W-1:0]  rd_data_b;
    logic               pend_set;
    logic [REG_AW-1:0]  pend_addr;
    logic               wb_en;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               out_valid;
    logic               out_ready;
    logic [REG_AW-1:0]  out_addr_a;
    logic [REG_AW-1:0]  out_addr_b;
    logic [DATA_W-1:0]  out_data_a;
    logic [DATA_W-1:0]  out_data_b;
    logic [DATA_W-1:0]  out_imm;
    logic [3:0]         out_ctrl;
    logic [15:0]        stall_cnt;

    modport slave (
        input  in_valid, mach_code, RegDst, MemtoReg, MemWrite, Branch,
               rd_data_a, rd_data_b, pend_set, pend_addr,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, rd_addr_a, rd_addr_b, out_valid,
               out_addr_a, out_addr_b, out_data_a, out_data_b,
               out_imm, out_ctrl, stall_cnt
    );

    modport master (
        output in_valid, mach_code, RegDst, MemtoReg, MemWrite, Branch,
               rd_data_a, rd_data_b, pend_set, pend_addr,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, rd_addr_a, rd_addr_b, out_valid,
               out_addr_a, out_addr_b, out_data_a, out_data_b,
               out_imm, out_ctrl, stall_cnt
    );

endinterface

// File: rtl/operand_decode_stage_field_decode.sv
// Combinational operand-field decoder: picks read addresses, immediate and the
// set of operands the instruction actually reads, according to the control flags.
module operand_field_decode
    import operand_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int REG_AW  = 2,
    parameter int DATA_W  = 8
) (
    input  logic [INSTR_W-1:0] i_mach_code,
    input  ctrl_t              i_ctrl,
    output logic [REG_AW-1:0]  o_addr_a,
    output logic [REG_AW-1:0]  o_addr_b,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_need_a,
    output logic               o_need_b
);
    localparam int F0_LSB = field_lsb(FIELD_F0, REG_AW);
    localparam int F1_LSB = field_lsb(FIELD_F1, REG_AW);
    localparam int F2_LSB = field_lsb(FIELD_F2, REG_AW);

    logic [REG_AW-1:0]   w_f0;
    logic [REG_AW-1:0]   w_f1;
    logic [REG_AW-1:0]   w_f2;
    logic [2*REG_AW-1:0] w_low;
    mode_e               w_mode;
    logic                w_unused_bits;

    assign w_f0          = i_mach_code[F0_LSB +: REG_AW];
    assign w_f1          = i_mach_code[F1_LSB +: REG_AW];
    assign w_f2          = i_mach_code[F2_LSB +: REG_AW];
    assign w_low         = i_mach_code[2*REG_AW-1:0];
    assign w_mode        = decode_mode(i_ctrl);
    assign w_unused_bits = ^i_mach_code;

    // Field mapping per mode; in IMM mode A is decoded but never read.
    always_comb begin
        o_addr_a = w_f0;
        o_addr_b = w_f1;
        o_imm    = '0;
        o_need_a = 1'b1;
        o_need_b = 1'b1;
        case (w_mode)
            MODE_IMM: begin
                o_addr_a = w_f0;
                o_addr_b = w_f2;
                o_imm    = DATA_W'(w_low);
                o_need_a = 1'b0;
            end
            MODE_MEM: begin
                o_addr_a = w_f1;
                o_addr_b = w_f2;
                o_imm    = '0;
            end
            MODE_REG: begin
                o_addr_a = w_f0;
                o_addr_b = w_f1;
                o_imm    = DATA_W'(w_f0);
            end
            default: begin
                o_addr_a = w_f0;
                o_addr_b = w_f1;
                o_imm    = '0;
            end
        endcase
    end

endmodule

// File: rtl/operand_decode_stage.sv
// Operand-decode pipeline stage: load-hazard scoreboard, writeback forwarding,
// one-entry valid/ready pipeline register and a saturating stall counter.
module operand_decode_stage
    import operand_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int NREGS   = 4,
    parameter int DATA_W  = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    operand_decode_stage_if.slave bus
);
    localparam int REG_AW = $clog2(NREGS);

    ctrl_t             w_ctrl;
    logic [REG_AW-1:0] w_addr_a;
    logic [REG_AW-1:0] w_addr_b;
    logic [DATA_W-1:0] w_imm;
    logic              w_need_a;
    logic              w_need_b;
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_capture;
    logic [NREGS-1:0]  w_pend_next;

    logic [NREGS-1:0]  r_pending;
    logic              r_out_valid;
    logic [REG_AW-1:0] r_addr_a;
    logic [REG_AW-1:0] r_addr_b;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [DATA_W-1:0] r_imm;
    ctrl_t             r_ctrl;
    logic [15:0]       r_stall_cnt;

    function automatic logic [NREGS-1:0] onehot(input logic [REG_AW-1:0] a);
        logic [NREGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    assign w_ctrl = {bus.RegDst, bus.MemtoReg, bus.MemWrite, bus.Branch};

    operand_field_decode #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .DATA_W  (DATA_W)
    ) u_field_decode (
        .i_mach_code (bus.mach_code),
        .i_ctrl      (w_ctrl),
        .o_addr_a    (w_addr_a),
        .o_addr_b    (w_addr_b),
        .o_imm       (w_imm),
        .o_need_a    (w_need_a),
        .o_need_b    (w_need_b)
    );

    // A same-cycle writeback both resolves the hazard and supplies the operand.
    assign w_fwd_a    = bus.wb_en && (bus.wb_addr == w_addr_a);
    assign w_fwd_b    = bus.wb_en && (bus.wb_addr == w_addr_b);
    assign w_data_a   = w_fwd_a ? bus.wb_data : bus.rd_data_a;
    assign w_data_b   = w_fwd_b ? bus.wb_data : bus.rd_data_b;
    assign w_hazard   = bus.in_valid &&
                        ((w_need_a && r_pending[w_addr_a] && !w_fwd_a) ||
                         (w_need_b && r_pending[w_addr_b] && !w_fwd_b));
    assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard;
    assign w_capture  = bus.in_valid && w_in_ready;

    // Set is applied after clear so a claim wins over a writeback to the same register.
    assign w_pend_next = (r_pending & ~(bus.wb_en ? onehot(bus.wb_addr) : '0)) |
                         (bus.pend_set ? onehot(bus.pend_addr) : '0);

    // Pending-load scoreboard.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_next;
        end
    end

    // One-entry pipeline register; payload only changes on capture.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_addr_a    <= w_addr_a;
            r_addr_b    <= w_addr_b;
            r_data_a    <= w_data_a;
            r_data_b    <= w_data_b;
            r_imm       <= w_imm;
            r_ctrl      <= w_ctrl;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating hazard-stall counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.rd_addr_a  = w_addr_a;
    assign bus.rd_addr_b  = w_addr_b;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_addr_a = r_addr_a;
    assign bus.out_addr_b = r_addr_b;
    assign bus.out_data_a = r_data_a;
    assign bus.out_data_b = r_data_b;
    assign bus.out_imm    = r_imm;
    assign bus.out_ctrl   = r_ctrl;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule
